// File: rtl/ila_capture.sv
// Integrated logic analyser: masked/counted trigger into a circular sample buffer
// with a runtime pre-trigger depth and a synchronous logical-index readout port.
module ila_capture #(
    parameter int DATA_W = 64,
    parameter int TRIG_W = 3,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] data,
    input  logic [TRIG_W-1:0] trig,
    input  logic [TRIG_W-1:0] trig_mask,
    input  logic [TRIG_W-1:0] trig_value,
    input  logic [ADDR_W-1:0] pre_trig,
    input  logic [CNT_W-1:0]  trig_count,
    output logic              armed,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_e;

    function automatic logic trig_match(input logic [TRIG_W-1:0] t,
                                        input logic [TRIG_W-1:0] v,
                                        input logic [TRIG_W-1:0] m);
        return ((t ^ v) & m) == {TRIG_W{1'b0}};
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] post_left_q, post_left_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              armed_q, triggered_q, done_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              wr_en_s;
    logic              match_s;
    logic [ADDR_W-1:0] rd_phys_s;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign match_s   = trig_match(trig, trig_value, trig_mask);
    assign rd_phys_s = start_q + rd_addr;

    // Capture sequencing: next state, pointers, counters and the buffer write enable.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        pre_d       = pre_q;
        start_d     = start_q;
        post_left_d = post_left_q;
        match_cnt_d = match_cnt_q;
        cnt_d       = cnt_q;
        wr_en_s     = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        pre_d       = pre_trig;
                        cnt_d       = (trig_count == {CNT_W{1'b0}}) ? CNT_W'(1) : trig_count;
                        fill_d      = {ADDR_W{1'b0}};
                        match_cnt_d = {CNT_W{1'b0}};
                        state_d     = (pre_trig == {ADDR_W{1'b0}}) ? S_WAIT : S_PRE;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_PRE: begin
                    if (sample_en) begin
                        wr_en_s = 1'b1;
                        fill_d  = fill_q + ADDR_W'(1);
                        state_d = (fill_d == pre_q) ? S_WAIT : S_PRE;
                    end else begin
                        state_d = S_PRE;
                    end
                end
                S_WAIT: begin
                    if (sample_en) begin
                        wr_en_s = 1'b1;
                        if (match_s) begin
                            match_cnt_d = match_cnt_q + CNT_W'(1);
                            if (match_cnt_d == cnt_q) begin
                                start_d = wr_ptr_q - pre_q;
                                // All-ones minus pre_trig is the remaining post-trigger room.
                                post_left_d = ~pre_q;
                                state_d     = (pre_q == {ADDR_W{1'b1}}) ? S_DONE : S_POST;
                            end else begin
                                state_d = S_WAIT;
                            end
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_POST: begin
                    if (sample_en) begin
                        wr_en_s     = 1'b1;
                        post_left_d = post_left_q - ADDR_W'(1);
                        state_d     = (post_left_q == ADDR_W'(1)) ? S_DONE : S_POST;
                    end else begin
                        state_d = S_POST;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Control state, counters and status flags (flags decoded from the next state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= {ADDR_W{1'b0}};
            fill_q      <= {ADDR_W{1'b0}};
            pre_q       <= {ADDR_W{1'b0}};
            start_q     <= {ADDR_W{1'b0}};
            post_left_q <= {ADDR_W{1'b0}};
            match_cnt_q <= {CNT_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            pre_q       <= pre_d;
            start_q     <= start_d;
            post_left_q <= post_left_d;
            match_cnt_q <= match_cnt_d;
            cnt_q       <= cnt_d;
            armed_q     <= (state_d == S_PRE) || (state_d == S_WAIT);
            triggered_q <= (state_d == S_POST) || (state_d == S_DONE);
            done_q      <= (state_d == S_DONE);
        end
    end

    // Sample buffer write port; contents intentionally have no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    // Registered readout; a same-address write this cycle leaves old data here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= mem_q[rd_phys_s];
            end else begin
                rd_data_q <= rd_data_q;
            end
        end
    end

    assign armed     = armed_q;
    assign triggered = triggered_q;
    assign done      = done_q;
    assign trig_addr = pre_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_ila_capture.sv
// Bench for ila_capture: directed and randomized captures checked against a
// sample-list reference model of the capture window.
module tb_ila_capture;
    localparam int DATA_W = 64;
    localparam int TRIG_W = 3;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 8;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rst_n;
    logic              arm;
    logic              abort;
    logic              sample_en;
    logic [DATA_W-1:0] data;
    logic [TRIG_W-1:0] trig;
    logic [TRIG_W-1:0] trig_mask;
    logic [TRIG_W-1:0] trig_value;
    logic [ADDR_W-1:0] pre_trig;
    logic [CNT_W-1:0]  trig_count;
    logic              armed;
    logic              triggered;
    logic              done;
    logic [ADDR_W-1:0] trig_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    int n_checks = 0;
    int n_fail   = 0;

    ila_capture #(.DATA_W(DATA_W), .TRIG_W(TRIG_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .sample_en(sample_en),
        .data(data), .trig(trig), .trig_mask(trig_mask), .trig_value(trig_value),
        .pre_trig(pre_trig), .trig_count(trig_count), .armed(armed), .triggered(triggered),
        .done(done), .trig_addr(trig_addr), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // stop_mode: 0 = run to DONE and read back, 1 = stop at trigger, 2 = stop after pre+2 samples
    task automatic capture(input int pre, input int cnt, input logic [2:0] mask,
                           input logic [2:0] val, input bit rand_data, input bit rand_trig,
                           input logic [63:0] pulses, input int en_mode, input int stop_mode);
        logic [63:0] q[$];
        logic [63:0] d;
        logic [2:0]  tr;
        logic        en;
        int n, mc, t, eff, cyc;
        bit found, fin, cap_done;
        eff = (cnt == 0) ? 1 : cnt;
        pre_trig = ADDR_W'(pre);
        trig_count = CNT_W'(cnt);
        trig_mask = mask;
        trig_value = val;
        sample_en = 1'b0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("armed_after_arm", {63'd0, armed}, 64'd1);
        check("done_after_arm", {63'd0, done}, 64'd0);
        n = 0; mc = 0; t = 0; cyc = 0;
        found = 1'b0; fin = 1'b0; cap_done = 1'b0;
        while (!fin && cyc < 2000) begin
            case (en_mode)
                0: en = 1'b1;
                1: en = (cyc % 2 == 0);
                default: en = 1'($urandom_range(0, 1));
            endcase
            d = rand_data ? {$urandom, $urandom} : 64'(n);
            if (!en) d = {$urandom, $urandom};
            if (rand_trig || !en) tr = 3'($urandom);
            else tr = {2'($urandom), (n < 64) ? pulses[n] : 1'b0};
            sample_en = en;
            data = d;
            trig = tr;
            step();
            cyc++;
            if (en) begin
                q.push_back(d);
                if (!found && n >= pre && (((tr ^ val) & mask) == 3'b000)) begin
                    mc++;
                    if (mc == eff) begin
                        found = 1'b1;
                        t = n;
                    end
                end
                n++;
            end
            cap_done = found && (n >= t + DEPTH - pre);
            check("armed", {63'd0, armed}, {63'd0, !found});
            check("triggered", {63'd0, triggered}, {63'd0, found});
            check("done", {63'd0, done}, {63'd0, cap_done});
            case (stop_mode)
                0: fin = cap_done;
                1: fin = found;
                default: fin = (n == pre + 2);
            endcase
        end
        sample_en = 1'b0;
        check("capture_budget", {63'd0, fin}, 64'd1);
        if (stop_mode == 0 && fin) begin
            // Buffer must stay frozen in DONE even with qualified samples arriving.
            for (int j = 0; j < 3; j++) begin
                sample_en = 1'b1;
                data = {$urandom, $urandom};
                trig = 3'($urandom);
                step();
            end
            sample_en = 1'b0;
            check("done_hold", {63'd0, done}, 64'd1);
            check("trig_addr", {60'd0, trig_addr}, 64'(pre));
            rd_en = 1'b1;
            for (int k = 0; k < DEPTH; k++) begin
                rd_addr = ADDR_W'(k);
                step();
                check("rd_valid", {63'd0, rd_valid}, 64'd1);
                check("rd_data", rd_data, q[t - pre + k]);
            end
            rd_en = 1'b0;
            step();
            check("rd_valid_low", {63'd0, rd_valid}, 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; sample_en = 1'b0; data = 64'd0;
        trig = 3'd0; trig_mask = 3'd0; trig_value = 3'd0; pre_trig = 4'd0;
        trig_count = 8'd0; rd_en = 1'b0; rd_addr = 4'd0;
        step();
        step();
        check("rst_armed", {63'd0, armed}, 64'd0);
        check("rst_triggered", {63'd0, triggered}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_trig_addr", {60'd0, trig_addr}, 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        rst_n = 1'b1;
        step();

        capture(4, 1, 3'b001, 3'b001, 1'b0, 1'b0, 64'd1 << 20, 0, 0);
        capture(0, 1, 3'b001, 3'b001, 1'b0, 1'b0, 64'd1, 0, 0);
        capture(2, 3, 3'b001, 3'b001, 1'b0, 1'b0, (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 14), 0, 0);
        capture(8, 1, 3'b001, 3'b001, 1'b0, 1'b0, (64'd1 << 3) | (64'd1 << 9), 0, 0);
        capture(5, 1, 3'b001, 3'b001, 1'b0, 1'b0, 64'd1 << 20, 1, 0);
        capture(15, 0, 3'b001, 3'b001, 1'b0, 1'b0, 64'd1 << 20, 0, 0);
        capture(6, 2, 3'b000, 3'b101, 1'b1, 1'b1, 64'd0, 2, 0);

        // Abort (together with a competing arm) while waiting for the trigger.
        capture(4, 1, 3'b001, 3'b001, 1'b0, 1'b0, 64'd0, 0, 2);
        abort = 1'b1;
        arm = 1'b1;
        step();
        abort = 1'b0;
        arm = 1'b0;
        check("abort_armed", {63'd0, armed}, 64'd0);
        check("abort_triggered", {63'd0, triggered}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        step();
        check("abort_done_later", {63'd0, done}, 64'd0);
        capture(3, 1, 3'b001, 3'b001, 1'b0, 1'b0, 64'd1 << 7, 0, 0);

        for (int r = 0; r < 6; r++) begin
            capture(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 3'($urandom),
                    3'($urandom), 1'b1, 1'b1, 64'd0, 2, 0);
        end

        // Asynchronous reset while in POST.
        capture(4, 1, 3'b001, 3'b001, 1'b0, 1'b0, 64'd1 << 6, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_armed", {63'd0, armed}, 64'd0);
        check("arst_triggered", {63'd0, triggered}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("arst_trig_addr", {60'd0, trig_addr}, 64'd0);
        check("arst_rd_data", rd_data, 64'd0);
        #10;
        rst_n = 1'b1;
        step();
        capture(4, 1, 3'b001, 3'b001, 1'b0, 1'b0, 64'd1 << 20, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
